// File: rtl/mano_basic_computer.sv
// Mano Basic Computer: 4096x16 memory, datapath registers and hardwired control.
// Executes one microoperation step per clock; memory can be preloaded through a side-band port.
`timescale 1ns/1ps
module mano_basic_computer #(
  parameter logic [11:0] RESET_PC  = 12'd0,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en,
  input  logic [11:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic [7:0]  inpr_in,
  input  logic        inpr_strobe,
  input  logic        out_ack,
  output logic [7:0]  outr,
  output logic [15:0] ac,
  output logic [11:0] pc,
  output logic        halted,
  output logic        ien
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} sc_t;

  sc_t           sc, sc_n;
  logic [DW-1:0] ac_n, dr, dr_n, ir, ir_n, tr, tr_n;
  logic [AW-1:0] ar, ar_n, pc_n;
  logic [7:0]    inpr, inpr_n, outr_n;
  logic          e, e_n, i, i_n, s, s_n, r, r_n, ien_n;
  logic          fgi, fgi_n, fgo, fgo_n;

  logic [DW-1:0] mem [MEM_WORDS];
  logic [DW-1:0] mem_rd;
  logic          mem_we;
  logic [DW-1:0] mem_wd;

  logic [2:0]    sc_inc;
  logic [2:0]    opc;
  logic          d7;
  logic [DW:0]   sum;

  assign mem_rd = mem[ar];
  assign opc    = ir[14:12];
  assign d7     = (opc == 3'b111);
  assign halted = ~s;

  // Next-state and microoperation decode
  always_comb begin
    sc_inc = sc + 3'd1;
    sum    = {1'b0, ac} + {1'b0, dr};
    sc_n   = sc;
    ac_n   = ac;
    dr_n   = dr;
    ir_n   = ir;
    tr_n   = tr;
    ar_n   = ar;
    pc_n   = pc;
    inpr_n = inpr;
    outr_n = outr;
    e_n    = e;
    i_n    = i;
    s_n    = s;
    r_n    = r;
    ien_n  = ien;
    fgi_n  = fgi;
    fgo_n  = fgo;
    mem_we = 1'b0;
    mem_wd = '0;

    if (s) begin
      sc_n = sc_t'(sc_inc);

      if (sc != T0 && sc != T1 && sc != T2 && ien && (fgi || fgo))
        r_n = 1'b1;

      case (sc)
        T0: begin
          if (!r) ar_n = pc;
          else begin
            ar_n = '0;
            tr_n = {4'h0, pc};
          end
        end
        T1: begin
          if (!r) begin
            ir_n = mem_rd;
            pc_n = pc + 12'd1;
          end else begin
            mem_we = 1'b1;
            mem_wd = tr;
            pc_n   = '0;
          end
        end
        T2: begin
          if (!r) begin
            ar_n = ir[11:0];
            i_n  = ir[15];
          end else begin
            pc_n  = pc + 12'd1;
            ien_n = 1'b0;
            r_n   = 1'b0;
            sc_n  = T0;
          end
        end
        T3: begin
          if (d7) begin
            sc_n = T0;
            if (!i) begin
              // Register reference: later-listed AC/E writers override earlier ones
              if (ir[11]) ac_n = '0;
              if (ir[10]) e_n = 1'b0;
              if (ir[9])  ac_n = ~ac;
              if (ir[8])  e_n = ~e;
              if (ir[7]) begin
                ac_n = {e, ac[15:1]};
                e_n  = ac[0];
              end
              if (ir[6]) begin
                ac_n = {ac[14:0], e};
                e_n  = ac[15];
              end
              if (ir[5]) ac_n = ac + 16'd1;
              if ((ir[4] && !ac[15]) || (ir[3] && ac[15]) ||
                  (ir[2] && (ac == '0)) || (ir[1] && !e))
                pc_n = pc + 12'd1;
              if (ir[0]) s_n = 1'b0;
            end else begin
              if (ir[11]) begin
                ac_n  = {ac[15:8], inpr};
                fgi_n = 1'b0;
              end
              if (ir[10]) begin
                outr_n = ac[7:0];
                fgo_n  = 1'b0;
              end
              if ((ir[9] && fgi) || (ir[8] && fgo)) pc_n = pc + 12'd1;
              if (ir[7]) ien_n = 1'b1;
              if (ir[6]) ien_n = 1'b0;
            end
          end else if (i) begin
            ar_n = mem_rd[11:0];
          end
        end
        T4: begin
          if (!d7) begin
            case (opc)
              3'd0, 3'd1, 3'd2, 3'd6: dr_n = mem_rd;
              3'd3: begin
                mem_we = 1'b1;
                mem_wd = ac;
                sc_n   = T0;
              end
              3'd4: begin
                pc_n = ar;
                sc_n = T0;
              end
              3'd5: begin
                mem_we = 1'b1;
                mem_wd = {4'h0, pc};
                ar_n   = ar + 12'd1;
              end
              default: ;
            endcase
          end
        end
        T5: begin
          if (!d7) begin
            case (opc)
              3'd0: begin
                ac_n = ac & dr;
                sc_n = T0;
              end
              3'd1: begin
                ac_n = sum[15:0];
                e_n  = sum[16];
                sc_n = T0;
              end
              3'd2: begin
                ac_n = dr;
                sc_n = T0;
              end
              3'd5: begin
                pc_n = ar;
                sc_n = T0;
              end
              3'd6: dr_n = dr + 16'd1;
              default: ;
            endcase
          end
        end
        T6: begin
          if (!d7 && opc == 3'd6) begin
            mem_we = 1'b1;
            mem_wd = dr;
            if (dr == '0) pc_n = pc + 12'd1;
            sc_n = T0;
          end
        end
        default: ;
      endcase
    end

    if (!fgi) inpr_n = inpr_in;
    // Device handshakes win over same-cycle INP/OUT clears
    if (inpr_strobe) fgi_n = 1'b1;
    if (out_ack)     fgo_n = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      sc   <= T0;
      pc   <= RESET_PC;
      ac   <= '0;
      dr   <= '0;
      ar   <= '0;
      ir   <= '0;
      tr   <= '0;
      inpr <= '0;
      outr <= '0;
      e    <= 1'b0;
      i    <= 1'b0;
      s    <= 1'b1;
      r    <= 1'b0;
      ien  <= 1'b0;
      fgi  <= 1'b0;
      fgo  <= 1'b1;
    end else begin
      sc   <= sc_n;
      pc   <= pc_n;
      ac   <= ac_n;
      dr   <= dr_n;
      ar   <= ar_n;
      ir   <= ir_n;
      tr   <= tr_n;
      inpr <= inpr_n;
      outr <= outr_n;
      e    <= e_n;
      i    <= i_n;
      s    <= s_n;
      r    <= r_n;
      ien  <= ien_n;
      fgi  <= fgi_n;
      fgo  <= fgo_n;
    end
  end

  // Memory: CPU writes while running, preload only in reset or halt
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[ar] <= mem_wd;
    else if (ld_en && (reset || !s))
      mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_mano_basic_computer.sv
// Directed bench for mano_basic_computer: preloads small programs and checks
// architectural state against hand-computed results with immediate assertions.
`timescale 1ns/1ps
module tb_mano_basic_computer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;
  logic [7:0]  inpr_in;
  logic        inpr_strobe;
  logic        out_ack;
  logic [7:0]  outr;
  logic [15:0] ac;
  logic [11:0] pc;
  logic        halted;
  logic        ien;

  int tests  = 0;
  int failed = 0;

  mano_basic_computer #(.RESET_PC(12'd50), .MEM_WORDS(4096)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .inpr_in(inpr_in), .inpr_strobe(inpr_strobe), .out_ack(out_ack),
    .outr(outr), .ac(ac), .pc(pc), .halted(halted), .ien(ien)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ien(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (ien === val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    inpr_in = 8'h44; inpr_strobe = 1'b0; out_ack = 1'b0;

    // Multiply 5*4 via BSA subroutine and ISZ loop, loaded during reset
    preload(12'd50, 16'h203C); preload(12'd51, 16'h5046);
    preload(12'd52, 16'h7800); preload(12'd53, 16'h103D);
    preload(12'd54, 16'h603C); preload(12'd55, 16'h4035);
    preload(12'd56, 16'h303E); preload(12'd57, 16'h7001);
    preload(12'd60, 16'h0005); preload(12'd61, 16'h0004);
    preload(12'd71, 16'h7200); preload(12'd72, 16'h7020);
    preload(12'd73, 16'h303C); preload(12'd74, 16'hC046);
    tick();
    check("rst_pc", 32'(pc), 32'd50);
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_outr", 32'(outr), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_ien", 32'(ien), 32'h0);
    check("rst_sc", 32'(dut.sc), 32'h0);
    check("rst_fgo", 32'(dut.fgo), 32'h1);
    reset = 1'b0;
    run_to_halt(2000, ok);
    check("mul_halt", 32'(ok), 32'h1);
    check("mul_m62", 32'(dut.mem[62]), 32'h0014);
    check("mul_m60", 32'(dut.mem[60]), 32'h0000);
    check("mul_ac", 32'(ac), 32'h0014);
    check("mul_pc", 32'(pc), 32'd58);

    // Interrupt: main does OUT, LDA 0x1234, ION, spins at 0x13; ISR at 1
    reset = 1'b1;
    preload(12'd50, 16'h4010);
    preload(12'h010, 16'hF400); preload(12'h011, 16'h2020);
    preload(12'h012, 16'hF080); preload(12'h013, 16'h4013);
    preload(12'h020, 16'h1234); preload(12'h000, 16'h0000);
    preload(12'h001, 16'hF200); preload(12'h002, 16'h4005);
    preload(12'h003, 16'h3015); preload(12'h004, 16'hF800);
    preload(12'h005, 16'hF400); preload(12'h006, 16'h2015);
    preload(12'h007, 16'hF080); preload(12'h008, 16'hC000);
    tick();
    reset = 1'b0;
    wait_ien(1'b1, 200, ok);
    check("irq_ion", 32'(ok), 32'h1);
    repeat (3) tick();
    inpr_strobe = 1'b1;
    tick();
    inpr_strobe = 1'b0;
    wait_ien(1'b0, 50, ok);
    check("irq_taken", 32'(ok), 32'h1);
    wait_ien(1'b1, 300, ok);
    check("irq_return", 32'(ok), 32'h1);
    repeat (16) tick();
    check("irq_m0", 32'(dut.mem[0]), 32'h0013);
    check("irq_outr", 32'(outr), 32'h44);
    check("irq_m15", 32'(dut.mem[21]), 32'h1234);
    check("irq_ac", 32'(ac), 32'h1234);
    check("irq_ien", 32'(ien), 32'h1);
    check("irq_ir", 32'(dut.ir), 32'h4013);
    check("irq_pc", 32'((pc == 12'h013) || (pc == 12'h014)), 32'h1);

    // CIL on AC=8001, E=0
    reset = 1'b1;
    preload(12'd50, 16'h2040); preload(12'd51, 16'h7040);
    preload(12'd52, 16'h7001); preload(12'h040, 16'h8001);
    tick();
    reset = 1'b0;
    run_to_halt(200, ok);
    check("cil_halt", 32'(ok), 32'h1);
    check("cil_ac", 32'(ac), 32'h0002);
    check("cil_e", 32'(dut.e), 32'h1);

    // CIR on AC=0001, E=1 (E set by CME)
    reset = 1'b1;
    preload(12'd50, 16'h2041); preload(12'd51, 16'h7100);
    preload(12'd52, 16'h7080); preload(12'd53, 16'h7001);
    preload(12'h041, 16'h0001);
    tick();
    reset = 1'b0;
    run_to_halt(200, ok);
    check("cir_ac", 32'(ac), 32'h8000);
    check("cir_e", 32'(dut.e), 32'h1);

    // ADD carry-out, then SZA skips the INC
    reset = 1'b1;
    preload(12'd50, 16'h2042); preload(12'd51, 16'h1043);
    preload(12'd52, 16'h7004); preload(12'd53, 16'h7020);
    preload(12'd54, 16'h7001);
    preload(12'h042, 16'hFFFF); preload(12'h043, 16'h0001);
    tick();
    reset = 1'b0;
    run_to_halt(200, ok);
    check("add_halt", 32'(ok), 32'h1);
    check("add_ac", 32'(ac), 32'h0000);
    check("add_e", 32'(dut.e), 32'h1);
    check("add_pc", 32'(pc), 32'd55);

    // Halted machine holds state for 20 clocks; preload still works
    repeat (20) tick();
    check("hold_halted", 32'(halted), 32'h1);
    check("hold_ac", 32'(ac), 32'h0000);
    check("hold_pc", 32'(pc), 32'd55);
    check("hold_e", 32'(dut.e), 32'h1);
    check("hold_sc", 32'(dut.sc), 32'h0);
    check("hold_m42", 32'(dut.mem[66]), 32'hFFFF);
    preload(12'h100, 16'hABCD);
    tick();
    check("halt_preload", 32'(dut.mem[256]), 32'hABCD);

    // Reset in the middle of ISZ at T5
    reset = 1'b1;
    preload(12'd50, 16'hF400); preload(12'd51, 16'h2042);
    preload(12'd52, 16'h6044); preload(12'd53, 16'h7001);
    preload(12'h044, 16'h0007);
    tick();
    reset = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (dut.ir === 16'h6044 && dut.sc === 3'd5) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("isz_reach_t5", 32'(ok), 32'h1);
    check("isz_fgo_pre", 32'(dut.fgo), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("isz_rst_pc", 32'(pc), 32'd50);
    check("isz_rst_sc", 32'(dut.sc), 32'h0);
    check("isz_rst_ac", 32'(ac), 32'h0);
    check("isz_rst_fgo", 32'(dut.fgo), 32'h1);
    check("isz_rst_mem", 32'(dut.mem[68]), 32'h0007);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
